// File: rtl/wb_stage_pipe.sv
// Registered MEM/WB stage: one-entry valid/ready register, sub-word load extension, write-back mux.
// Optional retire counter is enabled by defining RETIRE_CNT_EN.
module wb_stage_pipe #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              valid_MEM,
    output logic              ready_MEM,
    input  logic              regwrite_MEM,
    input  logic [2:0]        wbsel_MEM,
    input  logic [REG_AW-1:0] rd_MEM,
    input  logic [2:0]        funct3_MEM,
    input  logic [1:0]        addrlo_MEM,
    input  logic [XLEN-1:0]   aluout_MEM,
    input  logic [XLEN-1:0]   rdata_MEM,
    input  logic [XLEN-1:0]   immext_MEM,
    input  logic [XLEN-1:0]   pcimmaui_MEM,
    input  logic [XLEN-1:0]   pcnext_MEM,
    input  logic              flush_WB,
    input  logic              wb_ready,
    output logic              valid_WB,
    output logic              regwrite_WB,
    output logic [REG_AW-1:0] rd_WB,
    output logic [XLEN-1:0]   wbout_WB,
    output logic [CNT_W-1:0]  retire_cnt
);

    logic              valid_q, valid_d;
    logic              regwrite_q, regwrite_d;
    logic [2:0]        wbsel_q, wbsel_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [XLEN-1:0]   aluout_q, aluout_d;
    logic [XLEN-1:0]   ldext_q, ldext_d;
    logic [XLEN-1:0]   immext_q, immext_d;
    logic [XLEN-1:0]   pcimm_q, pcimm_d;
    logic [XLEN-1:0]   pcnext_q, pcnext_d;

    logic       accept;
    logic       retire;
    logic [7:0] byte_sel;
    logic [15:0] half_sel;
    logic [XLEN-1:0] ldext_calc;

    assign ready_MEM = !valid_q || wb_ready;
    assign accept    = valid_MEM && ready_MEM && !flush_WB;
    assign retire    = valid_q && wb_ready;

    // Halfword lane ignores addrlo[0]; misaligned halves are not realigned here.
    always_comb begin
        byte_sel   = 8'h00;
        half_sel   = addrlo_MEM[1] ? rdata_MEM[31:16] : rdata_MEM[15:0];
        ldext_calc = rdata_MEM;
        case (addrlo_MEM)
            2'd0:    byte_sel = rdata_MEM[7:0];
            2'd1:    byte_sel = rdata_MEM[15:8];
            2'd2:    byte_sel = rdata_MEM[23:16];
            default: byte_sel = rdata_MEM[31:24];
        endcase
        case (funct3_MEM)
            3'd0:    ldext_calc = {{24{byte_sel[7]}}, byte_sel};
            3'd1:    ldext_calc = {{16{half_sel[15]}}, half_sel};
            3'd4:    ldext_calc = {24'h000000, byte_sel};
            3'd5:    ldext_calc = {16'h0000, half_sel};
            default: ldext_calc = rdata_MEM;
        endcase
    end

    always_comb begin
        valid_d    = valid_q;
        regwrite_d = regwrite_q;
        wbsel_d    = wbsel_q;
        rd_d       = rd_q;
        aluout_d   = aluout_q;
        ldext_d    = ldext_q;
        immext_d   = immext_q;
        pcimm_d    = pcimm_q;
        pcnext_d   = pcnext_q;
        // Flush only kills validity; payload fields may stay stale.
        if (flush_WB) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
        end else if (retire) begin
            valid_d = 1'b0;
        end
        if (accept) begin
            regwrite_d = regwrite_MEM;
            wbsel_d    = wbsel_MEM;
            rd_d       = rd_MEM;
            aluout_d   = aluout_MEM;
            ldext_d    = ldext_calc;
            immext_d   = immext_MEM;
            pcimm_d    = pcimmaui_MEM;
            pcnext_d   = pcnext_MEM;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            wbsel_q    <= 3'd0;
            rd_q       <= '0;
            aluout_q   <= '0;
            ldext_q    <= '0;
            immext_q   <= '0;
            pcimm_q    <= '0;
            pcnext_q   <= '0;
        end else begin
            valid_q    <= valid_d;
            regwrite_q <= regwrite_d;
            wbsel_q    <= wbsel_d;
            rd_q       <= rd_d;
            aluout_q   <= aluout_d;
            ldext_q    <= ldext_d;
            immext_q   <= immext_d;
            pcimm_q    <= pcimm_d;
            pcnext_q   <= pcnext_d;
        end
    end

    always_comb begin
        wbout_WB = '0;
        case (wbsel_q)
            3'd0:    wbout_WB = aluout_q;
            3'd1:    wbout_WB = ldext_q;
            3'd2:    wbout_WB = immext_q;
            3'd3:    wbout_WB = pcimm_q;
            3'd4:    wbout_WB = pcnext_q;
            default: wbout_WB = '0;
        endcase
    end

    assign valid_WB    = valid_q;
    assign rd_WB       = rd_q;
    assign regwrite_WB = valid_q && regwrite_q && (rd_q != '0);

`ifdef RETIRE_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (retire) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign retire_cnt = cnt_q;
`else
    assign retire_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/wb_stage_pipe.md
Name: wb_stage_pipe

Overview:
Parametrised registered write-back stage for the pipelined RISC-V core. Captures MEM-stage results into a one-entry MEM/WB register with a valid/ready handshake, and sign- or zero-extends sub-word loads from the byte offset. Selects the write-back value and drives the register-file write port. Supports flush and back-pressure from the register-file write port.

Parameters:
XLEN, 32, data width; must be 32 (byte/half/word lanes only)
REG_AW, 5, register address width
CNT_W, 32, retire counter width (used only with optional feature)

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
valid_MEM  in  1  MEM stage holds a valid instruction
ready_MEM  out  1  stage can accept from MEM this cycle
regwrite_MEM  in  1  instruction writes rd
wbsel_MEM  in  3  0 alu, 1 load, 2 imm, 3 pc+imm, 4 pc+4
rd_MEM  in  REG_AW  destination register
funct3_MEM  in  3  load type
addrlo_MEM  in  2  load address bits [1:0]
aluout_MEM  in  XLEN  ALU result
rdata_MEM  in  XLEN  raw memory read word
immext_MEM  in  XLEN  extended immediate
pcimmaui_MEM  in  XLEN  PC+imm
pcnext_MEM  in  XLEN  PC+4
flush_WB  in  1  discard held and incoming entry
wb_ready  in  1  register-file port accepts write this cycle
valid_WB  out  1  entry held
regwrite_WB  out  1  qualified register write strobe
rd_WB  out  REG_AW  destination register
wbout_WB  out  XLEN  write-back data
retire_cnt  out  CNT_W  retired instruction count (feature only)

Behaviour:
- Reset (rstn low, asynchronous): valid_WB=0, regwrite_WB=0, rd_WB=0, wbout_WB=0, retire_cnt=0; all internal registers cleared.
- ready_MEM = !valid_WB || wb_ready (combinational; no dependence on valid_MEM).
- Accept = valid_MEM && ready_MEM && !flush_WB. On accept, the register loads all MEM fields next edge; latency 1 cycle.
- Retire = valid_WB && wb_ready. If retire and no accept: valid_WB clears next edge. If both: entry replaced, valid_WB stays 1.
- No retire and valid_WB=1: entry holds all fields stable.
- flush_WB=1: valid_WB=0 next edge; the incoming entry is dropped and the held entry is dropped. Flush has priority over accept and hold.
- regwrite_WB = valid_WB && regwrite_q && (rd_q != 0): a write to x0 is never strobed.
- Load extension, computed at capture and registered. Byte = rdata >> (8*addrlo); half = addrlo[1] ? rdata[31:16] : rdata[15:0], so addrlo[0] is ignored.
  - funct3 0 LB: sign-extend byte.
  - funct3 1 LH: sign-extend half.
  - funct3 4 LBU: zero-extend byte.
  - funct3 5 LHU: zero-extend half.
  - funct3 2, 3, 6, 7: full word.
- wbout_WB mux uses the registered wbsel: 0..4 as listed in the port description; 5..7 select 0.
- wbout_WB and rd_WB reflect the held entry even when valid_WB=0 (stale data is allowed); consumers qualify with regwrite_WB.
- rd_WB is driven when valid_WB=1 so the hazard unit can forward from it.

Optional Feature:
RETIRE_CNT_EN:
- Defined: retire_cnt increments by 1 on every retire cycle (valid_WB && wb_ready), wraps modulo 2^CNT_W, and is unaffected by flush.
- Undefined: no counter register; retire_cnt is tied to 0.

Test Plan:
- Reset mid-stream: hold valid_MEM=1, pulse rstn low asynchronously between edges -> valid_WB=0 and wbout_WB=0 immediately; first accept after release appears 1 cycle later.
- LB, rdata=0x80FF7F01, addrlo=3, wbsel=1 -> wbout_WB=0xFFFFFF80. LBU, addrlo=1 -> 0x0000007F. LH, addrlo=2 -> 0xFFFF80FF. LHU, addrlo=3 -> 0x000080FF.
- Back-pressure: wb_ready=0 for 3 cycles with valid_MEM=1 -> ready_MEM=0 and the held entry is stable; when wb_ready=1, one retire occurs and the next entry is accepted the same cycle.
- Flush during accept: valid_MEM=1, flush_WB=1 -> next cycle valid_WB=0 and regwrite_WB=0.
- rd=0 with regwrite_MEM=1, wbsel=4, pcnext=0x104 -> valid_WB=1, regwrite_WB=0, wbout_WB=0x104. wbsel=6 -> wbout_WB=0.
- RETIRE_CNT_EN with CNT_W=4: 17 back-to-back retires -> retire_cnt=1 after wrap. Without the macro -> retire_cnt stays 0.
